// File: rtl/memory_arbiter_rr.sv
// memory_arbiter_rr: round-robin arbiter sharing one fixed-latency instruction-memory read port among N_REQ requesters.
// Optional grant/stall statistics counters are enabled by defining MEM_ARB_STATS_EN.
module memory_arbiter_rr #(
    parameter int N_REQ             = 4,
    parameter int MEMORY_ADDR_WIDTH = 11,
    parameter int MEMORY_WIDTH      = 16,
    parameter int MEM_LATENCY       = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [N_REQ-1:0]                   req_valid,
    input  logic [N_REQ*MEMORY_ADDR_WIDTH-1:0] req_addr,
    output logic [N_REQ-1:0]                   req_ready,
    output logic [MEMORY_WIDTH-1:0]            rsp_data,
    output logic                               mem_en,
    output logic [MEMORY_ADDR_WIDTH-1:0]       mem_addr,
    input  logic [MEMORY_WIDTH-1:0]            mem_data,
    output logic                               busy,
    output logic [31:0]                        stat_grants,
    output logic [31:0]                        stat_stalls
);
    localparam int IW = $clog2(N_REQ);
    localparam int AW = MEMORY_ADDR_WIDTH;

    logic [N_REQ-1:0] inflight, inflight_nx, eligible, gnt_oh;
    logic [IW-1:0] ptr, gnt_id;
    logic gnt;
    logic [MEM_LATENCY:0] pipe_v;
    logic [MEM_LATENCY:0][IW-1:0] pipe_id;

    assign eligible = req_valid & ~inflight;

    always_comb begin
        gnt = 1'b0;
        gnt_id = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!gnt && eligible[(int'(ptr) + k) % N_REQ]) begin
                gnt = 1'b1;
                gnt_id = IW'((int'(ptr) + k) % N_REQ);
            end
        end
    end

    assign gnt_oh = gnt ? N_REQ'(1) << gnt_id : '0;
    // the in-flight bit stays set through the ready cycle, so a held request is re-granted the cycle after
    assign inflight_nx = (inflight & ~req_ready) | gnt_oh;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr       <= '0;
            inflight  <= '0;
            mem_en    <= 1'b0;
            mem_addr  <= '0;
            pipe_v    <= '0;
            pipe_id   <= '0;
            req_ready <= '0;
            rsp_data  <= '0;
            busy      <= 1'b0;
        end else begin
            ptr       <= gnt ? (gnt_id == IW'(N_REQ - 1) ? '0 : gnt_id + IW'(1)) : ptr;
            inflight  <= inflight_nx;
            mem_en    <= gnt;
            if (gnt) mem_addr <= req_addr[gnt_id*AW +: AW];
            pipe_v    <= {pipe_v[MEM_LATENCY-1:0], gnt};
            pipe_id   <= {pipe_id[MEM_LATENCY-1:0], gnt_id};
            req_ready <= pipe_v[MEM_LATENCY] ? N_REQ'(1) << pipe_id[MEM_LATENCY] : '0;
            if (pipe_v[MEM_LATENCY]) rsp_data <= mem_data;
            busy      <= |inflight_nx | gnt;
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic stall;
    assign stall = |(eligible & ~gnt_oh);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_grants <= '0;
            stat_stalls <= '0;
        end else begin
            if (gnt && !(&stat_grants)) stat_grants <= stat_grants + 32'd1;
            if (stall && !(&stat_stalls)) stat_stalls <= stat_stalls + 32'd1;
        end
    end
`else
    assign stat_grants = '0;
    assign stat_stalls = '0;
`endif
endmodule
